// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
// Optional perf counters are enabled with FETCH_PERF_CNT_EN.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN,
        JUMP
    } state_t;

    localparam logic [15:0] NOP_INSTR = 16'h4000;

    localparam int unsigned DEF_PC_W = 32;
    localparam int unsigned DEF_RESET_VECTOR = 32;
    localparam int unsigned DEF_INT_VECTOR = 0;
    localparam int unsigned DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/fetch_ctrl_perf.sv
// Saturating stall/flush cycle counters for the fetch controller.
// Instantiated only when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall_evt,
    input  logic        i_flush_evt,
    output logic [15:0] o_stall_cycles,
    output logic [15:0] o_flush_cycles
);

    logic [15:0] r_stall;
    logic [15:0] r_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (i_stall_evt && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
            if (i_flush_evt && r_flush != 16'hFFFF)
                r_flush <= r_flush + 16'd1;
        end
    end

    assign o_stall_cycles = r_stall;
    assign o_flush_cycles = r_flush;

endmodule

// File: rtl/fetch_controller.sv
// Next-PC sequencing for the fetch stage: stall, redirect, interrupt entry.
// Define FETCH_PERF_CNT_EN to add stall_cycles/flush_cycles outputs.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W         = DEF_PC_W,
    parameter int unsigned RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned INT_VECTOR   = DEF_INT_VECTOR,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            int_req,
    output logic            int_ack,
    output logic [PC_W-1:0] saved_pc,
    output logic            saved_pc_valid,
    output logic            pc_enable,
    output logic            pc_write,
    output logic [PC_W-1:0] pc_write_back_value,
    output logic            clear_instruction
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]     stall_cycles,
    output logic [15:0]     flush_cycles
`endif
);

    localparam logic [PC_W-1:0] RV = PC_W'(RESET_VECTOR);
    localparam logic [PC_W-1:0] IV = PC_W'(INT_VECTOR);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam bit DIRECT_JUMP = (DRAIN_CYCLES == 1);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [PC_W-1:0] r_spc;
    logic [PC_W-1:0] r_saved;
    logic            r_pend;

    always_comb begin
        pc_enable           = 1'b0;
        pc_write            = 1'b0;
        pc_write_back_value = r_spc;
        clear_instruction   = 1'b1;
        int_ack             = 1'b0;
        saved_pc_valid      = 1'b0;
        unique case (r_state)
            BOOT: begin
            end
            RUN: begin
                pc_enable = 1'b1;
                if (redirect) begin
                    pc_write            = 1'b1;
                    pc_write_back_value = redirect_target;
                end else if (r_pend) begin
                    clear_instruction = 1'b1;
                end else if (stall) begin
                    clear_instruction = 1'b0;
                end else begin
                    pc_write            = 1'b1;
                    pc_write_back_value = r_spc + PC_W'(1);
                    clear_instruction   = 1'b0;
                end
            end
            DRAIN: begin
                pc_enable = 1'b1;
            end
            JUMP: begin
                pc_enable           = 1'b1;
                pc_write            = 1'b1;
                pc_write_back_value = IV;
                int_ack             = 1'b1;
                saved_pc_valid      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign saved_pc = r_saved;

    // spc is frozen outside pc_write, so capturing it on JUMP entry is exact
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
            r_cnt   <= '0;
            r_spc   <= RV;
            r_saved <= '0;
            r_pend  <= 1'b0;
        end else begin
            if (pc_write)
                r_spc <= pc_write_back_value;
            unique case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    if (int_req)
                        r_pend <= 1'b1;
                end
                RUN: begin
                    if (int_req)
                        r_pend <= 1'b1;
                    if (!redirect && r_pend) begin
                        r_cnt <= DRAIN_LOAD;
                        if (DIRECT_JUMP) begin
                            r_state <= JUMP;
                            r_saved <= r_spc;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= JUMP;
                        r_saved <= r_spc;
                    end
                end
                JUMP: begin
                    r_pend  <= 1'b0;
                    r_state <= RUN;
                end
                default: r_state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_stall_evt;
    logic w_flush_evt;

    assign w_stall_evt = (r_state == RUN) && stall && !redirect;
    assign w_flush_evt = clear_instruction && (r_state != BOOT);

    fetch_ctrl_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .i_stall_evt    (w_stall_evt),
        .i_flush_evt    (w_flush_evt),
        .o_stall_cycles (stall_cycles),
        .o_flush_cycles (flush_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized + directed bench for fetch_controller against a NOP-countdown model.
// Perf counter checks are compiled in with FETCH_PERF_CNT_EN.
module tb_fetch_controller;

    localparam int DRAIN = 3;
    localparam logic [31:0] RV = 32'd32;
    localparam logic [31:0] IV = 32'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        int_req = 1'b0;
    logic        int_ack;
    logic [31:0] saved_pc;
    logic        saved_pc_valid;
    logic        pc_enable;
    logic        pc_write;
    logic [31:0] pc_write_back_value;
    logic        clear_instruction;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_cycles;
`endif

    fetch_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .redirect            (redirect),
        .redirect_target     (redirect_target),
        .int_req             (int_req),
        .int_ack             (int_ack),
        .saved_pc            (saved_pc),
        .saved_pc_valid      (saved_pc_valid),
        .pc_enable           (pc_enable),
        .pc_write            (pc_write),
        .pc_write_back_value (pc_write_back_value),
        .clear_instruction   (clear_instruction)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles        (stall_cycles),
        .flush_cycles        (flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model: boot flag, pending irq, NOP cycles still owed, jump due
    bit          m_boot;
    bit          m_jump;
    bit          m_pend;
    int          m_nops;
    logic [31:0] m_pc;
    logic [31:0] m_saved;
    int          m_stallc;
    int          m_flushc;

    logic        snap_wr;
    logic        snap_clr;
    logic        snap_ack;
    logic [31:0] snap_val;
    logic [31:0] snap_saved;

    task automatic model_reset();
        m_boot = 1'b1;
        m_jump = 1'b0;
        m_pend = 1'b0;
        m_nops = 0;
        m_pc = RV;
        m_saved = '0;
        m_stallc = 0;
        m_flushc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        int_req = 1'b0;
        #1;
        chk("rst_en", 64'(pc_enable), 64'(0));
        chk("rst_wr", 64'(pc_write), 64'(0));
        chk("rst_clr", 64'(clear_instruction), 64'(1));
        chk("rst_ack", 64'(int_ack), 64'(0));
        chk("rst_spv", 64'(saved_pc_valid), 64'(0));
        chk("rst_saved", 64'(saved_pc), 64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input bit s, input bit r, input logic [31:0] t,
                        input bit irq);
        bit          e_wr;
        bit          e_clr;
        bit          e_ack;
        bit          run;
        logic [31:0] e_val;
        logic [31:0] e_saved;
        @(negedge clk);
        stall = s;
        redirect = r;
        redirect_target = t;
        int_req = irq;
        #1;
        e_wr = 1'b0;
        e_clr = 1'b1;
        e_ack = 1'b0;
        e_val = '0;
        e_saved = m_saved;
        run = 1'b0;
        if (m_boot) begin
        end else if (m_jump) begin
            e_wr = 1'b1;
            e_val = IV;
            e_ack = 1'b1;
            e_saved = m_pc;
        end else if (m_nops > 0) begin
        end else begin
            run = 1'b1;
            if (r) begin
                e_wr = 1'b1;
                e_val = t;
            end else if (m_pend) begin
            end else if (s) begin
                e_clr = 1'b0;
            end else begin
                e_wr = 1'b1;
                e_val = m_pc + 32'd1;
                e_clr = 1'b0;
            end
        end
        chk("pc_enable", 64'(pc_enable), 64'(!m_boot));
        chk("pc_write", 64'(pc_write), 64'(e_wr));
        chk("clear", 64'(clear_instruction), 64'(e_clr));
        chk("int_ack", 64'(int_ack), 64'(e_ack));
        chk("saved_valid", 64'(saved_pc_valid), 64'(e_ack));
        chk("saved_pc", 64'(saved_pc), 64'(e_saved));
        if (e_wr)
            chk("pc_value", 64'(pc_write_back_value), 64'(e_val));
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cycles), 64'(m_stallc));
        chk("flush_cnt", 64'(flush_cycles), 64'(m_flushc));
`endif
        snap_wr = pc_write;
        snap_clr = clear_instruction;
        snap_ack = int_ack;
        snap_val = pc_write_back_value;
        snap_saved = saved_pc;
        @(posedge clk);
        if (!m_boot && e_clr && m_flushc < 65535)
            m_flushc++;
        if (run && s && !r && m_stallc < 65535)
            m_stallc++;
        if (m_boot) begin
            m_boot = 1'b0;
            m_pend = m_pend | irq;
        end else if (m_jump) begin
            m_jump = 1'b0;
            m_pend = 1'b0;
            m_saved = m_pc;
        end else if (m_nops > 0) begin
            m_nops--;
            if (m_nops == 0)
                m_jump = 1'b1;
        end else begin
            if (!r && m_pend) begin
                m_nops = DRAIN - 1;
                if (m_nops == 0)
                    m_jump = 1'b1;
            end
            m_pend = m_pend | irq;
        end
        if (e_wr)
            m_pc = e_val;
    endtask

    task automatic wait_ack(output int nops);
        nops = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (snap_ack)
                return;
            if (snap_clr && !snap_wr)
                nops++;
        end
        chk("ack_timeout", 64'(snap_ack), 64'(1));
    endtask

    initial begin
        int nops;
        model_reset();
        do_reset();

        step(1'b0, 1'b0, '0, 1'b0);
        chk("boot_clr", 64'(snap_clr), 64'(1));
        chk("boot_wr", 64'(snap_wr), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            chk("seq_pc", 64'(snap_val), 64'(33 + i));
        end
        repeat (5) step(1'b0, 1'b0, '0, 1'b0);

        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            chk("stall_wr", 64'(snap_wr), 64'(0));
            chk("stall_clr", 64'(snap_clr), 64'(0));
        end
        step(1'b0, 1'b0, '0, 1'b0);
        chk("post_stall", 64'(snap_val), 64'(41));

        repeat (9) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'd100, 1'b0);
        chk("redir_val", 64'(snap_val), 64'(100));
        chk("redir_clr", 64'(snap_clr), 64'(1));
        step(1'b0, 1'b0, '0, 1'b0);
        chk("redir_next", 64'(snap_val), 64'(101));

        step(1'b0, 1'b1, 32'd59, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        wait_ack(nops);
        chk("int_nops", 64'(nops), 64'(3));
        chk("int_saved", 64'(snap_saved), 64'(60));
        chk("int_vec", 64'(snap_val), 64'(0));
        step(1'b0, 1'b0, '0, 1'b0);
        chk("int_next", 64'(snap_val), 64'(1));

        step(1'b0, 1'b1, 32'd200, 1'b1);
        chk("combo_redir", 64'(snap_val), 64'(200));
        wait_ack(nops);
        chk("combo_saved", 64'(snap_saved), 64'(200));

        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        do_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("restart_pc", 64'(snap_val), 64'(33));

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0)
                do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
